// File: rtl/rom_shadow_copier_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rom_shadow_copier_pkg                                           |
// | Brief    : Shared FSM state type and default ROM/RAM map constants for the |
// |            boot ROM shadow copier, ROM wrapper and RAM controller.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package rom_shadow_copier_pkg;

    // Boot ROM is 16 KiB; its image is shadowed at the top quarter of RAM.
    localparam int unsigned c_default_rom_addr_width = 14;
    localparam int unsigned c_default_ram_base       = 32'h0000_C000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

endpackage : rom_shadow_copier_pkg
`default_nettype wire

// File: rtl/rom_shadow_copier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rom_shadow_copier                                               |
// | Brief    : Boot-time engine copying the boot ROM image into external SRAM  |
// |            over a req/ack write port while holding the CPU off the bus.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rom_shadow_copier
    import rom_shadow_copier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ROM_ADDR_WIDTH = c_default_rom_addr_width,
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned RAM_BASE       = c_default_ram_base,
    parameter int unsigned COPY_LEN       = 2 ** ROM_ADDR_WIDTH,
    parameter int unsigned ROM_LATENCY    = 1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    output logic                      ram_req,
    input  logic                      ram_ack,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      cpu_hold
);

    // Counter widths: latency counter spans 0..ROM_LATENCY, timeout counter
    // spans 0..ACK_TIMEOUT-1 (one bit kept when the timeout is disabled).
    localparam int unsigned LAT_W = $clog2(ROM_LATENCY + 1);
    localparam int unsigned TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [RAM_ADDR_WIDTH-1:0] c_ram_base = RAM_ADDR_WIDTH'(RAM_BASE);
    localparam logic [ROM_ADDR_WIDTH-1:0] c_last_idx = ROM_ADDR_WIDTH'(COPY_LEN - 1);
    localparam logic [LAT_W-1:0]          c_lat_end  = LAT_W'(ROM_LATENCY);
    localparam logic [TO_W-1:0]           c_to_end   = TO_W'(ACK_TIMEOUT - 1);

    state_e                    state_q,     state_d;
    logic                      auto_pend_q, auto_pend_d;
    logic [LAT_W-1:0]          lat_q,       lat_d;
    logic [TO_W-1:0]           to_q,        to_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q,  rom_addr_d;   // doubles as the word index
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
    logic                      ram_req_q,   ram_req_d;
    logic                      busy_q,      busy_d;
    logic                      done_q,      done_d;
    logic                      error_q,     error_d;
    logic                      cpu_hold_q,  cpu_hold_d;

    // Next-state and registered-output logic for the copy sequencer.
    always_comb begin
        state_d     = state_q;
        auto_pend_d = 1'b0;   // auto-start request lives for the first clock only
        lat_d       = lat_q;
        to_d        = to_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_req_d   = ram_req_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_hold_d  = cpu_hold_q;

        case (state_q)
            S_IDLE: begin
                if (start || auto_pend_q) begin
                    state_d    = S_READ;
                    rom_addr_d = '0;
                    lat_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end

            S_READ: begin
                // ROM data for rom_addr is valid after ROM_LATENCY clocks; the
                // extra cycle accounts for the registered address itself.
                if (lat_q == c_lat_end) begin
                    ram_wdata_d = rom_data;
                    ram_addr_d  = c_ram_base + RAM_ADDR_WIDTH'(rom_addr_q);
                    ram_req_d   = 1'b1;
                    to_d        = '0;
                    state_d     = S_WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_WRITE: begin
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    if (rom_addr_q == c_last_idx) begin
                        state_d = S_FINISH;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        lat_d      = '0;
                        state_d    = S_READ;
                    end
                end else if ((ACK_TIMEOUT != 0) && (to_q == c_to_end)) begin
                    // The ACK_TIMEOUT-th cycle without ack abandons the copy.
                    ram_req_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            S_FINISH: begin
                busy_d     = 1'b0;
                cpu_hold_d = 1'b0;
                done_d     = ~error_q;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending request immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            auto_pend_q <= AUTO_START;
            lat_q       <= '0;
            to_q        <= '0;
            rom_addr_q  <= '0;
            ram_addr_q  <= c_ram_base;
            ram_wdata_q <= '0;
            ram_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= AUTO_START;
        end else begin
            state_q     <= state_d;
            auto_pend_q <= auto_pend_d;
            lat_q       <= lat_d;
            to_q        <= to_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_req_q   <= ram_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_req   = ram_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_hold  = cpu_hold_q;

endmodule : rom_shadow_copier
`default_nettype wire

// File: tb/tb_rom_shadow_copier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rom_shadow_copier                                            |
// | Brief    : Self-checking bench for rom_shadow_copier using three DUT       |
// |            configurations, ROM/RAM models and a write-sequence reference.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rom_shadow_copier;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Instance A: ROM_LATENCY=1, COPY_LEN=4, AUTO_START=1, ACK_TIMEOUT=8
    // ------------------------------------------------------------------
    logic        rst_a_n = 1'b0, start_a = 1'b0, ack_a = 1'b0;
    logic [13:0] rom_addr_a;
    logic [7:0]  rom_data_a, ram_wdata_a;
    logic [15:0] ram_addr_a;
    logic        ram_req_a, busy_a, done_a, error_a, hold_a;
    logic [7:0]  rom_a [0:15];

    rom_shadow_copier #(.ROM_LATENCY(1), .COPY_LEN(4), .AUTO_START(1'b1), .ACK_TIMEOUT(8)) u_dut_a (
        .clock(clock), .reset_n(rst_a_n), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_req(ram_req_a), .ram_ack(ack_a),
        .busy(busy_a), .done(done_a), .error(error_a), .cpu_hold(hold_a));

    // ------------------------------------------------------------------
    // Instance B: ROM_LATENCY=2 (registered ROM output), ack tied high
    // ------------------------------------------------------------------
    logic        rst_b_n = 1'b0, start_b = 1'b0;
    logic        ack_b = 1'b1;
    logic [13:0] rom_addr_b;
    logic [7:0]  rom_data_b, ram_wdata_b, rom_b_s1;
    logic [15:0] ram_addr_b;
    logic        ram_req_b, busy_b, done_b, error_b, hold_b;
    logic [7:0]  rom_b [0:15];

    rom_shadow_copier #(.ROM_LATENCY(2), .COPY_LEN(4), .AUTO_START(1'b1)) u_dut_b (
        .clock(clock), .reset_n(rst_b_n), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_req(ram_req_b), .ram_ack(ack_b),
        .busy(busy_b), .done(done_b), .error(error_b), .cpu_hold(hold_b));

    // ------------------------------------------------------------------
    // Instance C: AUTO_START=0, RAM_BASE=FFFE, COPY_LEN=3, ack tied high
    // ------------------------------------------------------------------
    logic        rst_c_n = 1'b0, start_c = 1'b0;
    logic        ack_c = 1'b1;
    logic [13:0] rom_addr_c;
    logic [7:0]  rom_data_c, ram_wdata_c;
    logic [15:0] ram_addr_c;
    logic        ram_req_c, busy_c, done_c, error_c, hold_c;
    logic [7:0]  rom_c [0:15];

    rom_shadow_copier #(.RAM_BASE(32'hFFFE), .COPY_LEN(3), .ROM_LATENCY(1), .AUTO_START(1'b0)) u_dut_c (
        .clock(clock), .reset_n(rst_c_n), .start(start_c),
        .rom_addr(rom_addr_c), .rom_data(rom_data_c),
        .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .ram_req(ram_req_c), .ram_ack(ack_c),
        .busy(busy_c), .done(done_c), .error(error_c), .cpu_hold(hold_c));

    // Synchronous ROM models: one clock of latency, plus an output register for B.
    always @(posedge clock) begin
        rom_data_a <= rom_a[rom_addr_a[3:0]];
        rom_b_s1   <= rom_b[rom_addr_b[3:0]];
        rom_data_b <= rom_b_s1;
        rom_data_c <= rom_c[rom_addr_c[3:0]];
    end

    // RAM controller model for A: ack after delay_a waiting cycles (never if
    // never_a); logs accepted writes and any change of addr/data while waiting.
    int          delay_a = 0;
    bit          never_a = 1'b0;
    int          wait_a = 0, unstable_a = 0, req_cycles_a = 0;
    logic [15:0] hold_addr_a;
    logic [7:0]  hold_data_a;
    logic [15:0] wr_addr_a [$];
    logic [7:0]  wr_data_a [$];

    always @(negedge clock) begin
        if (rst_a_n && ram_req_a) begin
            if (wait_a == 0) begin
                hold_addr_a = ram_addr_a;
                hold_data_a = ram_wdata_a;
            end else if (ram_addr_a !== hold_addr_a || ram_wdata_a !== hold_data_a) begin
                unstable_a++;
            end
            req_cycles_a++;
            if (!never_a && wait_a >= delay_a) begin
                ack_a = 1'b1;
                wr_addr_a.push_back(ram_addr_a);
                wr_data_a.push_back(ram_wdata_a);
            end else begin
                ack_a = 1'b0;
            end
            wait_a++;
        end else begin
            ack_a  = 1'b0;
            wait_a = 0;
        end
    end

    // Write loggers for B and C; ack is tied high so each req cycle is one write.
    logic [15:0] wr_addr_b [$];
    logic [7:0]  wr_data_b [$];
    logic [15:0] wr_addr_c [$];
    logic [7:0]  wr_data_c [$];

    always @(negedge clock) begin
        if (rst_b_n && ram_req_b) begin
            wr_addr_b.push_back(ram_addr_b);
            wr_data_b.push_back(ram_wdata_b);
        end
        if (rst_c_n && ram_req_c) begin
            wr_addr_c.push_back(ram_addr_c);
            wr_data_c.push_back(ram_wdata_c);
        end
    end

    // Pulse reset on one instance and clear its logs.
    task automatic pulse_reset(input int sel);
        @(negedge clock);
        case (sel)
            0: rst_a_n = 1'b0;
            1: rst_b_n = 1'b0;
            default: rst_c_n = 1'b0;
        endcase
        repeat (2) @(negedge clock);
        wr_addr_a.delete(); wr_data_a.delete(); unstable_a = 0; req_cycles_a = 0;
        wr_addr_b.delete(); wr_data_b.delete();
        wr_addr_c.delete(); wr_data_c.delete();
        case (sel)
            0: rst_a_n = 1'b1;
            1: rst_b_n = 1'b1;
            default: rst_c_n = 1'b1;
        endcase
    endtask

    // Wait for busy to rise and fall on one instance; returns cycles busy was high.
    task automatic run_copy(input int sel, output int cyc, output bit ok);
        bit seen = 1'b0;
        bit b;
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock);
            b = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
            if (b) begin
                seen = 1'b1;
                cyc++;
            end else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [45:0] got, exp;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        repeat (2) @(negedge clock);
        got = {rom_addr_a, ram_addr_a, ram_wdata_a, ram_req_a, busy_a, done_a, error_a, hold_a, 3'b000};
        exp = {14'd0, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_a: got %h expected %h", got, exp); end
        got = {rom_addr_c, ram_addr_c, ram_wdata_c, ram_req_c, busy_c, done_c, error_c, hold_c, 3'b000};
        exp = {14'd0, 16'hFFFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_c: got %h expected %h", got, exp); end
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        repeat (60) @(negedge clock);   // let the auto-start copies settle
    endtask

    // Ack immediately, fixed image then random images; checks writes and timing.
    task automatic test_auto_copy();
        int cyc; bit ok;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) rom_a[i] = (r == 0 && i < 4) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            delay_a = 0; never_a = 1'b0;
            pulse_reset(0);
            run_copy(0, cyc, ok);
            n_checks++;
            if (!ok || cyc != 4 * (1 + 2) + 1) begin n_fail++; $display("FAIL auto_cycles run %0d: got %0d (ok=%0d) expected %0d", r, cyc, ok, 13); end
            n_checks++;
            if (wr_addr_a.size() != 4) begin n_fail++; $display("FAIL auto_count run %0d: got %0d expected 4", r, wr_addr_a.size()); end
            for (int i = 0; i < 4 && i < wr_addr_a.size(); i++) begin
                n_checks++;
                if (wr_addr_a[i] !== 16'(32'hC000 + i) || wr_data_a[i] !== rom_a[i]) begin
                    n_fail++;
                    $display("FAIL auto_write %0d: got (%h,%h) expected (%h,%h)", i, wr_addr_a[i], wr_data_a[i], 16'(32'hC000 + i), rom_a[i]);
                end
            end
            n_checks++;
            if ({done_a, error_a, hold_a} !== 3'b100) begin n_fail++; $display("FAIL auto_flags: got done/err/hold=%b expected 100", {done_a, error_a, hold_a}); end
        end
    endtask

    // Delayed ack: request must hold stable, exactly one write per word.
    task automatic test_ack_delay();
        int cyc; bit ok; int d;
        for (int r = 0; r < 3; r++) begin
            d = (r == 0) ? 3 : int'($urandom_range(1, 5));
            for (int i = 0; i < 16; i++) rom_a[i] = 8'($urandom);
            delay_a = d; never_a = 1'b0;
            pulse_reset(0);
            run_copy(0, cyc, ok);
            n_checks++;
            if (!ok || cyc != 4 * (1 + 2 + d) + 1) begin n_fail++; $display("FAIL delay_cycles d=%0d: got %0d expected %0d", d, cyc, 4 * (3 + d) + 1); end
            n_checks++;
            if (req_cycles_a != 4 * (d + 1) || unstable_a != 0) begin
                n_fail++; $display("FAIL delay_hold d=%0d: got req_cycles=%0d unstable=%0d expected %0d and 0", d, req_cycles_a, unstable_a, 4 * (d + 1));
            end
            n_checks++;
            if (wr_addr_a.size() != 4) begin n_fail++; $display("FAIL delay_count d=%0d: got %0d expected 4", d, wr_addr_a.size()); end
            for (int i = 0; i < 4 && i < wr_addr_a.size(); i++) begin
                n_checks++;
                if (wr_addr_a[i] !== 16'(32'hC000 + i) || wr_data_a[i] !== rom_a[i]) begin
                    n_fail++;
                    $display("FAIL delay_write %0d: got (%h,%h) expected (%h,%h)", i, wr_addr_a[i], wr_data_a[i], 16'(32'hC000 + i), rom_a[i]);
                end
            end
        end
    endtask

    // Ack never arrives: abort after 8 cycles, then software restart recovers.
    task automatic test_timeout();
        int cyc; bit ok;
        for (int i = 0; i < 16; i++) rom_a[i] = 8'($urandom);
        never_a = 1'b1; delay_a = 0;
        pulse_reset(0);
        run_copy(0, cyc, ok);
        n_checks++;
        if (!ok || cyc != (1 + 1) + 8 + 1) begin n_fail++; $display("FAIL timeout_cycles: got %0d (ok=%0d) expected 11", cyc, ok); end
        n_checks++;
        if (req_cycles_a != 8) begin n_fail++; $display("FAIL timeout_req_len: got %0d expected 8", req_cycles_a); end
        n_checks++;
        if ({done_a, error_a, hold_a, ram_req_a} !== 4'b0100 || rom_addr_a !== 14'd0 || wr_addr_a.size() != 0) begin
            n_fail++; $display("FAIL timeout_flags: got done/err/hold/req=%b rom_addr=%h writes=%0d expected 0100, 0, 0",
                               {done_a, error_a, hold_a, ram_req_a}, rom_addr_a, wr_addr_a.size());
        end
        repeat (10) @(negedge clock);
        n_checks++;
        if (busy_a !== 1'b0 || hold_a !== 1'b0) begin n_fail++; $display("FAIL timeout_no_restart: got busy=%b hold=%b expected 0 0", busy_a, hold_a); end
        never_a = 1'b0;
        wr_addr_a.delete(); wr_data_a.delete();
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        run_copy(0, cyc, ok);
        n_checks++;
        if (!ok || {done_a, error_a, hold_a} !== 3'b100 || wr_addr_a.size() != 4) begin
            n_fail++; $display("FAIL timeout_recover: got done/err/hold=%b writes=%0d expected 100 and 4", {done_a, error_a, hold_a}, wr_addr_a.size());
        end
    endtask

    // Asynchronous reset while word 2 is being written, then auto restart.
    task automatic test_reset_mid_copy();
        int cyc; bit ok; bit hit = 1'b0;
        logic [45:0] got, exp;
        for (int i = 0; i < 16; i++) rom_a[i] = 8'($urandom);
        delay_a = 3; never_a = 1'b0;
        pulse_reset(0);
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clock); #1;
            if (wr_addr_a.size() == 2 && ram_req_a && ram_addr_a == 16'hC002) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL midreset_reach: got no word-2 write expected one within 200 cycles"); end
        @(posedge clock); #2;
        rst_a_n = 1'b0;
        #1;
        got = {rom_addr_a, ram_addr_a, ram_wdata_a, ram_req_a, busy_a, done_a, error_a, hold_a, 3'b000};
        exp = {14'd0, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL midreset_values: got %h expected %h", got, exp); end
        @(negedge clock);
        wr_addr_a.delete(); wr_data_a.delete();
        @(negedge clock);
        rst_a_n = 1'b1;
        run_copy(0, cyc, ok);
        n_checks++;
        if (!ok || wr_addr_a.size() != 4 || done_a !== 1'b1) begin n_fail++; $display("FAIL midreset_restart: got writes=%0d done=%b expected 4 1", wr_addr_a.size(), done_a); end
        for (int i = 0; i < 4 && i < wr_addr_a.size(); i++) begin
            n_checks++;
            if (wr_addr_a[i] !== 16'(32'hC000 + i) || wr_data_a[i] !== rom_a[i]) begin
                n_fail++;
                $display("FAIL midreset_write %0d: got (%h,%h) expected (%h,%h)", i, wr_addr_a[i], wr_data_a[i], 16'(32'hC000 + i), rom_a[i]);
            end
        end
    endtask

    // Registered-output ROM: same write sequence, two extra cycles per word.
    task automatic test_latency2();
        int cyc; bit ok;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) rom_b[i] = (r == 0 && i < 4) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            pulse_reset(1);
            run_copy(1, cyc, ok);
            n_checks++;
            if (!ok || cyc != 4 * (2 + 2) + 1) begin n_fail++; $display("FAIL lat2_cycles run %0d: got %0d expected 17", r, cyc); end
            n_checks++;
            if (wr_addr_b.size() != 4 || {done_b, error_b, hold_b} !== 3'b100) begin
                n_fail++; $display("FAIL lat2_status run %0d: got writes=%0d done/err/hold=%b expected 4 100", r, wr_addr_b.size(), {done_b, error_b, hold_b});
            end
            for (int i = 0; i < 4 && i < wr_addr_b.size(); i++) begin
                n_checks++;
                if (wr_addr_b[i] !== 16'(32'hC000 + i) || wr_data_b[i] !== rom_b[i]) begin
                    n_fail++;
                    $display("FAIL lat2_write %0d: got (%h,%h) expected (%h,%h)", i, wr_addr_b[i], wr_data_b[i], 16'(32'hC000 + i), rom_b[i]);
                end
            end
        end
    endtask

    // Manual start, RAM address wrap, start while busy and in FINISH ignored.
    task automatic test_start_and_wrap();
        int cyc; bit ok; bit hit = 1'b0;
        for (int i = 0; i < 16; i++) rom_c[i] = 8'($urandom);
        pulse_reset(2);
        repeat (5) @(negedge clock);
        n_checks++;
        if (busy_c !== 1'b0 || hold_c !== 1'b0 || wr_addr_c.size() != 0) begin
            n_fail++; $display("FAIL start_no_auto: got busy=%b hold=%b writes=%0d expected 0 0 0", busy_c, hold_c, wr_addr_c.size());
        end
        start_c = 1'b1; @(negedge clock); start_c = 1'b0;
        repeat (3) @(negedge clock);
        start_c = 1'b1; @(negedge clock); start_c = 1'b0;
        run_copy(2, cyc, ok);
        repeat (20) @(negedge clock);
        n_checks++;
        if (!ok || wr_addr_c.size() != 3 || busy_c !== 1'b0 || done_c !== 1'b1) begin
            n_fail++; $display("FAIL start_single: got writes=%0d busy=%b done=%b expected 3 0 1", wr_addr_c.size(), busy_c, done_c);
        end
        for (int i = 0; i < 3 && i < wr_addr_c.size(); i++) begin
            n_checks++;
            if (wr_addr_c[i] !== 16'((32'hFFFE + i) % 32'h1_0000) || wr_data_c[i] !== rom_c[i]) begin
                n_fail++;
                $display("FAIL wrap_write %0d: got (%h,%h) expected (%h,%h)", i, wr_addr_c[i], wr_data_c[i], 16'((32'hFFFE + i) % 32'h1_0000), rom_c[i]);
            end
        end
        // Second copy; pulse start during the FINISH cycle right after the last write.
        wr_addr_c.delete(); wr_data_c.delete();
        start_c = 1'b1; @(negedge clock); start_c = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clock); #1;
            if (wr_addr_c.size() == 3) hit = 1'b1;
        end
        @(negedge clock);
        start_c = 1'b1; @(negedge clock); start_c = 1'b0;
        repeat (20) @(negedge clock);
        n_checks++;
        if (!hit || wr_addr_c.size() != 3 || busy_c !== 1'b0 || done_c !== 1'b1) begin
            n_fail++; $display("FAIL start_in_finish: got writes=%0d busy=%b done=%b expected 3 0 1", wr_addr_c.size(), busy_c, done_c);
        end
    endtask

    initial begin
        test_reset();
        test_auto_copy();
        test_ack_delay();
        test_timeout();
        test_reset_mid_copy();
        test_latency2();
        test_start_and_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rom_shadow_copier
`default_nettype wire

// File: doc/rom_shadow_copier.md
Name: rom_shadow_copier

Overview:
- Boot-time copy engine that reads the on-chip boot ROM image sequentially and writes each byte into external SRAM through a req/ack write port.
- Holds the CPU off the bus via cpu_hold until the copy completes, so the monitor runs from RAM.
- Sits between the boot ROM instance and the external-RAM controller on the S-100 SBC.
- Acts as the reader of the ROM and the writer of the RAM.

Parameters:
- DATA_WIDTH, 8: byte width of ROM and RAM data.
- ROM_ADDR_WIDTH, 14: ROM address width; the ROM holds 2**ROM_ADDR_WIDTH words.
- RAM_ADDR_WIDTH, 16: external RAM address width.
- RAM_BASE, 16'hC000: RAM address receiving ROM word 0.
- COPY_LEN, 2**ROM_ADDR_WIDTH: words copied. Legal range 1..2**ROM_ADDR_WIDTH.
- ROM_LATENCY, 1: ROM read latency in clocks. Use 1 for unregistered ROM output, 2 when the ROM output register is enabled.
- AUTO_START, 1: when 1, the copy begins automatically after reset release.
- ACK_TIMEOUT, 255: maximum cycles to wait for ram_ack per write. 0 disables the timeout.

Ports:
- clock, input, 1: single system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle pulse that starts a copy. Ignored while busy.
- rom_addr, output, ROM_ADDR_WIDTH: address to the boot ROM.
- rom_data, input, DATA_WIDTH: ROM read data.
- ram_addr, output, RAM_ADDR_WIDTH: external RAM write address.
- ram_wdata, output, DATA_WIDTH: external RAM write data.
- ram_req, output, 1: write request to the RAM controller.
- ram_ack, input, 1: write accepted. May be high in the same cycle as ram_req.
- busy, output, 1: copy in progress.
- done, output, 1: last copy completed successfully. Sticky.
- error, output, 1: last copy aborted on ack timeout. Sticky.
- cpu_hold, output, 1: holds the CPU off the bus.

Behaviour:
- Reset values: rom_addr=0, ram_addr=RAM_BASE, ram_wdata=0, ram_req=0, busy=0, done=0, error=0, cpu_hold=AUTO_START.
- All outputs are registered.
- FSM states: IDLE, READ, WRITE, FINISH.
- IDLE:
  - Go to READ on a start pulse, or on the first clock after reset release when AUTO_START=1.
  - On entry to READ: idx=0, busy=1, done=0, error=0, cpu_hold=1.
- READ:
  - rom_addr=idx is stable throughout.
  - Lasts exactly ROM_LATENCY+1 cycles, counted by a latency counter.
  - On the leaving edge, capture rom_data into ram_wdata, set ram_addr=RAM_BASE+idx (truncated to RAM_ADDR_WIDTH, wraps modulo 2**RAM_ADDR_WIDTH), set ram_req=1, and go to WRITE.
- WRITE:
  - ram_req, ram_addr and ram_wdata are held stable until ram_ack is sampled high.
  - On ack: ram_req=0 on the next edge.
  - If idx==COPY_LEN-1, go to FINISH. Otherwise idx+1 and go to READ.
  - The timeout counter resets on every WRITE entry.
  - If ACK_TIMEOUT≠0 and the count reaches ACK_TIMEOUT without ack: ram_req=0, error=1, go to FINISH.
- FINISH (one cycle):
  - busy=0 and cpu_hold=0.
  - done=1 unless error=1.
  - Go to IDLE.
- Throughput with zero-wait ack: ROM_LATENCY+2 cycles per word. Total for COPY_LEN words: COPY_LEN*(ROM_LATENCY+2)+1, counted from READ entry to busy falling.
- A start pulse while busy is ignored. A start pulse in the FINISH cycle is ignored.
- cpu_hold stays low after an error. Recovery is by software restart or reset.
- Reset mid-copy:
  - All state returns to reset values immediately (asynchronous).
  - Any pending ram_req drops without waiting for ack; the RAM controller tolerates an unacknowledged request.
  - With AUTO_START=1, the copy restarts from idx 0.
- COPY_LEN=1: exactly one READ/WRITE pass, then FINISH.

Decomposition:
- A shared package holds:
  - the FSM state typedef (IDLE/READ/WRITE/FINISH);
  - the default RAM_BASE and ROM_ADDR_WIDTH constants, also used by the ROM wrapper and RAM controller.
- No sub-module. The latency counter, timeout counter and FSM are small enough to stay in one block.

Test Plan:
- AUTO_START=1, ROM_LATENCY=1, COPY_LEN=4, ROM={11,22,33,44}, ack tied high -> writes (C000,11),(C001,22),(C002,33),(C003,44); busy falls 13 cycles after READ entry; done=1; cpu_hold=0.
- Same, with ROM_LATENCY=2 -> rom_data captured one cycle later; identical write sequence; 17 cycles total.
- ack delayed 3 cycles per write -> ram_req/addr/wdata held stable across the 3 wait cycles; exactly 4 writes; no duplicates.
- ACK_TIMEOUT=8, ack stuck low -> ram_req drops after 8 cycles; error=1; done=0; cpu_hold=0; rom_addr remains 0.
- reset_n asserted during write of word 2 -> all outputs immediately at reset values; after release the copy restarts at ram_addr C000.
- AUTO_START=0, RAM_BASE=16'hFFFE, COPY_LEN=3, start pulsed twice (second pulse while busy) -> single copy to FFFE, FFFF, 0000; second pulse ignored.
